// File: rtl/i2s_tx_tdm_channel.sv
// Multi-lane I2S/TDM transmitter slaved to an external WS; serialises slot-major FIFO words.
// Optional macro I2S_TX_WS_CHECK_EN adds WS misalignment detection on frame_err_o.
module i2s_tx_tdm_channel #(
   parameter int  NUM_LANES = 2,
   parameter int  DATA_W    = 32,
   parameter int  SLOT_W    = 3,
   localparam int LANE_W    = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1,
   localparam int WLEN_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1
) (
   input  logic                 sck_i,
   input  logic                 rstn_i,
   input  logic                 i2s_ws_i,
   output logic [NUM_LANES-1:0] i2s_sd_o,
   input  logic [DATA_W-1:0]    fifo_data_i,
   input  logic                 fifo_data_valid_i,
   output logic                 fifo_data_ready_o,
   output logic                 fifo_err_o,
   output logic [SLOT_W-1:0]    cur_slot_o,
   output logic                 frame_err_o,
   input  logic                 cfg_en_i,
   input  logic [LANE_W-1:0]    cfg_lanes_i,
   input  logic [WLEN_W-1:0]    cfg_wlen_i,
   input  logic [SLOT_W-1:0]    cfg_slots_i,
   input  logic                 cfg_lsb_first_i
);

   localparam int LD_W = $clog2(NUM_LANES + 1);

   typedef enum logic [1:0] {
      IDLE,
      PRELOAD,
      WAIT_WS,
      RUNNING
   } state_t;

   state_t                state_reg, state_next;
   logic                  ws_q_reg;
   logic [WLEN_W-1:0]     bit_cnt_reg;
   logic [SLOT_W-1:0]     slot_cnt_reg;
   logic [LD_W-1:0]       ld_idx_reg;
   logic                  fifo_err_reg;
   logic [NUM_LANES-1:0]  sd_reg;

   logic                  ws_edge;
   logic                  ws_start;
   logic                  ws_misalign;
   logic                  word_done;
   logic                  underrun;
   logic                  accept;
   logic [LD_W-1:0]       lanes_ext;
   logic [LD_W-1:0]       lanes_p1;
   logic [NUM_LANES-1:0]  lane_bit;

   assign lanes_ext = LD_W'(cfg_lanes_i);
   assign lanes_p1  = lanes_ext + LD_W'(1);
   assign ws_edge   = i2s_ws_i ^ ws_q_reg;
   assign ws_start  = (state_reg == WAIT_WS) && ws_edge;
   assign word_done = (state_reg == RUNNING) && (bit_cnt_reg == cfg_wlen_i);
   assign underrun  = word_done && (ld_idx_reg != lanes_p1);

   assign fifo_data_ready_o = ((state_reg == PRELOAD) || (state_reg == RUNNING)) &&
                              (ld_idx_reg <= lanes_ext) && !word_done;
   assign accept            = fifo_data_valid_i && fifo_data_ready_o;

`ifdef I2S_TX_WS_CHECK_EN
   logic frame_boundary;
   logic frame_err_reg;

   // Only the last bit of the last slot may coincide with a WS transition.
   assign frame_boundary = word_done && (slot_cnt_reg == cfg_slots_i);
   assign ws_misalign    = (state_reg == RUNNING) && ws_edge && !frame_boundary;

   always_ff @(posedge sck_i or negedge rstn_i) begin
      if (!rstn_i) begin
         frame_err_reg <= 1'b0;
      end else if (!cfg_en_i) begin
         frame_err_reg <= 1'b0;
      end else if (ws_misalign) begin
         frame_err_reg <= 1'b1;
      end
   end

   assign frame_err_o = frame_err_reg;
`else
   assign ws_misalign = 1'b0;
   assign frame_err_o = 1'b0;
`endif

   always_comb begin
      state_next = state_reg;
      if (!cfg_en_i) begin
         state_next = IDLE;
      end else begin
         case (state_reg)
            IDLE:    state_next = PRELOAD;
            PRELOAD: if (ld_idx_reg == lanes_p1) state_next = WAIT_WS;
            WAIT_WS: if (ws_edge) state_next = RUNNING;
            RUNNING: if (ws_misalign) state_next = PRELOAD;
            default: state_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge sck_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_reg    <= IDLE;
         ws_q_reg     <= 1'b0;
         bit_cnt_reg  <= '0;
         slot_cnt_reg <= '0;
         ld_idx_reg   <= '0;
         fifo_err_reg <= 1'b0;
      end else begin
         state_reg    <= state_next;
         ws_q_reg     <= i2s_ws_i;
         fifo_err_reg <= 1'b0;
         if (!cfg_en_i) begin
            bit_cnt_reg  <= '0;
            slot_cnt_reg <= '0;
            ld_idx_reg   <= '0;
         end else if (ws_start || ws_misalign) begin
            bit_cnt_reg  <= '0;
            slot_cnt_reg <= '0;
            ld_idx_reg   <= '0;
         end else if (word_done) begin
            // Missing lanes are not back-filled; the next slot loads from lane 0.
            bit_cnt_reg  <= '0;
            slot_cnt_reg <= (slot_cnt_reg == cfg_slots_i) ? '0 : slot_cnt_reg + SLOT_W'(1);
            ld_idx_reg   <= '0;
            fifo_err_reg <= underrun;
         end else begin
            if (state_reg == RUNNING) begin
               bit_cnt_reg <= bit_cnt_reg + WLEN_W'(1);
            end
            if (accept) begin
               ld_idx_reg <= ld_idx_reg + LD_W'(1);
            end
         end
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
         logic [DATA_W-1:0] shift_reg;
         logic [DATA_W-1:0] shadow_reg;
         logic              lane_active;
         logic              lane_filled;

         assign lane_active = (LD_W'(gi) <= lanes_ext);
         assign lane_filled = (LD_W'(gi) < ld_idx_reg);

         always_ff @(posedge sck_i or negedge rstn_i) begin
            if (!rstn_i) begin
               shift_reg  <= '0;
               shadow_reg <= '0;
            end else if (!cfg_en_i) begin
               shift_reg  <= '0;
               shadow_reg <= '0;
            end else begin
               if (accept && (ld_idx_reg == LD_W'(gi))) begin
                  shadow_reg <= fifo_data_i;
               end
               if (ws_start) begin
                  shift_reg <= lane_active ? shadow_reg : '0;
               end else if (ws_misalign) begin
                  shift_reg <= '0;
               end else if (word_done) begin
                  shift_reg <= (lane_active && lane_filled) ? shadow_reg : '0;
               end else if (state_reg == RUNNING) begin
                  shift_reg <= cfg_lsb_first_i ? (shift_reg >> 1) : (shift_reg << 1);
               end
            end
         end

         assign lane_bit[gi] = lane_active &
                               (cfg_lsb_first_i ? shift_reg[0] : shift_reg[cfg_wlen_i]);
      end
   endgenerate

   // Data changes on the falling edge so the receiver samples mid-bit on the rising edge.
   always_ff @(negedge sck_i or negedge rstn_i) begin
      if (!rstn_i) begin
         sd_reg <= '0;
      end else begin
         sd_reg <= (state_reg == RUNNING) ? lane_bit : '0;
      end
   end

   assign i2s_sd_o   = sd_reg;
   assign fifo_err_o = fifo_err_reg;
   assign cur_slot_o = slot_cnt_reg;

endmodule

// File: tb/tb_i2s_tx_tdm_channel.sv
// Bench for i2s_tx_tdm_channel: random FIFO traffic, slot-level reference model and a
// scoreboard monitor that rebuilds each serial word from the lanes.
`timescale 1ns/1ps
module tb_i2s_tx_tdm_channel;
   localparam int NUM_LANES = 2;
   localparam int DATA_W    = 32;
   localparam int SLOT_W    = 3;
   localparam int LANE_W    = 1;
   localparam int WLEN_W    = 5;

   logic                 sck_i = 1'b0;
   logic                 rstn_i = 1'b1;
   logic                 i2s_ws_i = 1'b0;
   logic [NUM_LANES-1:0] i2s_sd_o;
   logic [DATA_W-1:0]    fifo_data_i = '0;
   logic                 fifo_data_valid_i = 1'b0;
   logic                 fifo_data_ready_o;
   logic                 fifo_err_o;
   logic [SLOT_W-1:0]    cur_slot_o;
   logic                 frame_err_o;
   logic                 cfg_en_i = 1'b0;
   logic [LANE_W-1:0]    cfg_lanes_i = '0;
   logic [WLEN_W-1:0]    cfg_wlen_i = '0;
   logic [SLOT_W-1:0]    cfg_slots_i = '0;
   logic                 cfg_lsb_first_i = 1'b0;

   typedef struct packed {
      logic [NUM_LANES-1:0][DATA_W-1:0] w;
      logic [SLOT_W-1:0]                slot;
      logic                             err;
   } exp_t;

   exp_t              exp_q[$];
   logic [DATA_W-1:0] fifo_q[$];
   logic [DATA_W-1:0] stim_words[$];
   int                total = 0;
   int                bad = 0;
   bit                mon_armed = 1'b0;
   int                word_no = 0;

   i2s_tx_tdm_channel #(
      .NUM_LANES(NUM_LANES),
      .DATA_W   (DATA_W),
      .SLOT_W   (SLOT_W)
   ) dut (
      .sck_i            (sck_i),
      .rstn_i           (rstn_i),
      .i2s_ws_i         (i2s_ws_i),
      .i2s_sd_o         (i2s_sd_o),
      .fifo_data_i      (fifo_data_i),
      .fifo_data_valid_i(fifo_data_valid_i),
      .fifo_data_ready_o(fifo_data_ready_o),
      .fifo_err_o       (fifo_err_o),
      .cur_slot_o       (cur_slot_o),
      .frame_err_o      (frame_err_o),
      .cfg_en_i         (cfg_en_i),
      .cfg_lanes_i      (cfg_lanes_i),
      .cfg_wlen_i       (cfg_wlen_i),
      .cfg_slots_i      (cfg_slots_i),
      .cfg_lsb_first_i  (cfg_lsb_first_i)
   );

   always #5 sck_i = ~sck_i;

   task automatic tick();
      @(posedge sck_i);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, req);
      end
   endtask

   // FIFO source: presents the queue head; a word leaves the queue when the coming edge takes it.
   always begin
      tick();
      fifo_data_valid_i = (fifo_q.size() > 0);
      fifo_data_i       = (fifo_q.size() > 0) ? fifo_q[0] : '0;
      if (fifo_data_valid_i && fifo_data_ready_o) begin
         void'(fifo_q.pop_front());
      end
   end

   // Monitor: rebuild one word per lane, then compare with the scoreboard head.
   logic [NUM_LANES-1:0][DATA_W-1:0] acc;
   logic [SLOT_W-1:0]                slot_seen;
   logic                             err_first, err_rest, ferr_seen;
   int                               bitk = 0;
   exp_t                             mon_e;

   always begin
      @(negedge sck_i);
      #1;
      if (!mon_armed) begin
         bitk = 0;
      end else if (exp_q.size() > 0) begin
         if (bitk == 0) begin
            acc       = '0;
            slot_seen = cur_slot_o;
            err_first = fifo_err_o;
            err_rest  = 1'b0;
            ferr_seen = frame_err_o;
         end else begin
            err_rest  = err_rest | fifo_err_o;
            ferr_seen = ferr_seen | frame_err_o;
         end
         for (int l = 0; l < NUM_LANES; l++) begin
            if (cfg_lsb_first_i) acc[l][bitk] = i2s_sd_o[l];
            else                 acc[l] = {acc[l][DATA_W-2:0], i2s_sd_o[l]};
         end
         if (bitk == int'(cfg_wlen_i)) begin
            mon_e = exp_q.pop_front();
            $display("word %0d: slot=%0d lanes=%h err=%0b (expected slot=%0d lanes=%h err=%0b)",
                     word_no, slot_seen, acc, err_first, mon_e.slot, mon_e.w, mon_e.err);
            check("lane_data", acc, mon_e.w);
            check("cur_slot", 64'(slot_seen), 64'(mon_e.slot));
            check("err_flags", {61'd0, err_first, err_rest, ferr_seen}, {61'd0, mon_e.err, 2'b00});
            word_no++;
            bitk = 0;
         end else begin
            bitk++;
         end
      end
   end

   // Reference model: slot s, lane l carries FIFO word s*(L+1)+l if it exists, else zero.
   task automatic start_scenario(input int L, input int W, input int S, input bit lsb, input int K);
      logic [63:0] m;
      exp_t        e;
      int          n, idx;
      cfg_lanes_i     = LANE_W'(L);
      cfg_wlen_i      = WLEN_W'(W);
      cfg_slots_i     = SLOT_W'(S);
      cfg_lsb_first_i = lsb;
      n = stim_words.size();
      m = (64'd1 << (W + 1)) - 64'd1;
      for (int s = 0; s < K; s++) begin
         e = '0;
         for (int l = 0; l < NUM_LANES; l++) begin
            idx = s * (L + 1) + l;
            if (l <= L && idx < n) e.w[l] = stim_words[idx] & m[DATA_W-1:0];
         end
         e.slot = SLOT_W'(s % (S + 1));
         e.err  = (s > 0) && ((s + 1) * (L + 1) > n);
         exp_q.push_back(e);
      end
      foreach (stim_words[i]) fifo_q.push_back(stim_words[i]);
      tick();
      cfg_en_i = 1'b1;
      repeat (12) tick();
      check("wait_ws_quiet", {61'd0, fifo_data_ready_o, i2s_sd_o}, 64'd0);
      i2s_ws_i = ~i2s_ws_i;
      tick();
      mon_armed = 1'b1;
   endtask

   task automatic stop_dut();
      cfg_en_i = 1'b0;
      fifo_q.delete();
      tick();
      tick();
   endtask

   task automatic finish_scenario();
      int guard;
      guard = 0;
      while (exp_q.size() > 0 && guard < 3000) begin
         tick();
         guard++;
      end
      if (exp_q.size() > 0) begin
         total++;
         bad++;
         $display("FAIL scoreboard_timeout: %0d words pending, want 0", exp_q.size());
      end
      mon_armed = 1'b0;
      exp_q.delete();
      stop_dut();
   endtask

   task automatic rand_words(input int n);
      stim_words.delete();
      for (int i = 0; i < n; i++) stim_words.push_back($urandom);
   endtask

   initial begin
      #2 rstn_i = 1'b0;
      #1;
      check("reset_outputs",
            {56'd0, i2s_sd_o, fifo_data_ready_o, fifo_err_o, frame_err_o, cur_slot_o},
            64'd0);
      repeat (3) tick();
      rstn_i = 1'b1;
      tick();

      // Two lanes, two slots, MSB first
      stim_words = '{32'hA5A5A5A5, 32'h12345678, 32'h0F0F0F0F, 32'hF0F0F0F0};
      start_scenario(1, 31, 1, 1'b0, 2);
      finish_scenario();

      // TDM, single lane, four 16-bit slots, LSB first, wrap back to slot 0
      stim_words = '{32'h0001, 32'h0002, 32'h0003, 32'h0004, 32'h0005};
      start_scenario(0, 15, 3, 1'b1, 5);
      finish_scenario();

      // Underrun after the second slot
      rand_words(4);
      start_scenario(1, 31, 1, 1'b0, 3);
      finish_scenario();

      // Disable mid-word
      rand_words(4);
      start_scenario(1, 31, 1, 1'b0, 2);
      repeat (7) tick();
      mon_armed = 1'b0;
      exp_q.delete();
      cfg_en_i = 1'b0;
      tick();
      check("disable_ctrl", {60'd0, fifo_data_ready_o, fifo_err_o, cur_slot_o}, 64'd0);
      @(negedge sck_i);
      #1;
      check("disable_sd", 64'(i2s_sd_o), 64'd0);
      fifo_q.delete();
      tick();

      // Random configurations, including partial final slots
      for (int it = 0; it < 8; it++) begin
         int L, W, S, N, K;
         bit lsb;
         L   = $urandom_range(0, NUM_LANES - 1);
         W   = $urandom_range(3, 31);
         S   = $urandom_range(0, 7);
         lsb = 1'($urandom_range(0, 1));
         N   = $urandom_range(L + 1, 4 * (L + 1) + 1);
         K   = (N + L) / (L + 1) + 1;
         rand_words(N);
         start_scenario(L, W, S, lsb, K);
         finish_scenario();
      end

      // WS toggled in the middle of slot 0
      rand_words(4);
      start_scenario(0, 15, 1, 1'b0, 4);
`ifdef I2S_TX_WS_CHECK_EN
      mon_armed = 1'b0;
      exp_q.delete();
      repeat (4) tick();
      i2s_ws_i = ~i2s_ws_i;
      repeat (3) tick();
      check("frame_err_set", 64'(frame_err_o), 64'd1);
      repeat (20) tick();
      check("frame_err_sticky", 64'(frame_err_o), 64'd1);
      stop_dut();
      check("frame_err_cleared", 64'(frame_err_o), 64'd0);
`else
      repeat (4) tick();
      i2s_ws_i = ~i2s_ws_i;
      finish_scenario();
      check("frame_err_ignored", 64'(frame_err_o), 64'd0);
`endif

      // Asynchronous reset mid-frame
      rand_words(6);
      start_scenario(1, 20, 2, 1'b1, 3);
      repeat (9) tick();
      mon_armed = 1'b0;
      exp_q.delete();
      rstn_i = 1'b0;
      #1;
      check("reset_midframe",
            {56'd0, i2s_sd_o, fifo_data_ready_o, fifo_err_o, frame_err_o, cur_slot_o},
            64'd0);
      cfg_en_i = 1'b0;
      fifo_q.delete();
      tick();
      rstn_i = 1'b1;
      tick();

      // Clean restart after reset
      rand_words(6);
      start_scenario(1, 23, 2, 1'b0, 4);
      finish_scenario();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation still running, want finished");
      $fatal(1, "watchdog expired");
   end

endmodule
